// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module   : countdown_timer
// Brief    : MM:SS preset countdown with one-second prescaler and expiry pulse.
//            Optional feature macro: AUTO_RELOAD_EN (re-arm from stored preset).
// Revision : 1.0 - initial release
// ============================================================================
module countdown_timer #(
  parameter int TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] min_in,
  input  logic [5:0] sec_in,
  input  logic       start,
  input  logic       stop,
  input  logic       clr,
  output logic [7:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] status,
  output logic       expired
);

  localparam int PW = $clog2(TICK_DIV) + 1;

  localparam logic [1:0] S_IDLE    = 2'b00;
  localparam logic [1:0] S_PAUSED  = 2'b01;
  localparam logic [1:0] S_RUNNING = 2'b10;
  localparam logic [1:0] S_EXPIRED = 2'b11;

  localparam logic [PW-1:0] c_presc_last = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] c_presc_one  = PW'(1);
  localparam logic [5:0]    c_sec_max    = 6'd59;

  logic [1:0]    state_q, state_d;
  logic [7:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          expired_q, expired_d;

  logic [5:0]    w_sec_clamped;
  logic          w_count_nz;
  logic          w_final_tick;
  logic          w_load_acts;
  logic          w_reload_nz;
  logic [7:0]    w_reload_min;
  logic [5:0]    w_reload_sec;

  assign w_sec_clamped = (sec_in > c_sec_max) ? c_sec_max : sec_in;
  assign w_count_nz    = (min_q != 8'd0) || (sec_q != 6'd0);
  assign w_final_tick  = (min_q == 8'd0) && (sec_q == 6'd1);
  // load is simply ignored while running, so it must not mask stop/start there
  assign w_load_acts   = load && (state_q != S_RUNNING);

`ifdef AUTO_RELOAD_EN
  logic [7:0] reload_min_q, reload_min_d;
  logic [5:0] reload_sec_q, reload_sec_d;

  always_comb begin
    reload_min_d = reload_min_q;
    reload_sec_d = reload_sec_q;
    if (clr) begin
      reload_min_d = 8'd0;
      reload_sec_d = 6'd0;
    end else if (w_load_acts) begin
      reload_min_d = min_in;
      reload_sec_d = w_sec_clamped;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reload_min_q <= 8'd0;
      reload_sec_q <= 6'd0;
    end else begin
      reload_min_q <= reload_min_d;
      reload_sec_q <= reload_sec_d;
    end
  end

  assign w_reload_nz  = (reload_min_q != 8'd0) || (reload_sec_q != 6'd0);
  assign w_reload_min = reload_min_q;
  assign w_reload_sec = reload_sec_q;
`else
  assign w_reload_nz  = 1'b0;
  assign w_reload_min = 8'd0;
  assign w_reload_sec = 6'd0;
`endif

  always_comb begin
    state_d   = state_q;
    min_d     = min_q;
    sec_d     = sec_q;
    presc_d   = presc_q;
    expired_d = 1'b0;

    if (clr) begin
      state_d = S_IDLE;
      min_d   = 8'd0;
      sec_d   = 6'd0;
      presc_d = '0;
    end else if (w_load_acts) begin
      state_d = S_IDLE;
      min_d   = min_in;
      sec_d   = w_sec_clamped;
      presc_d = '0;
    end else if (stop) begin
      // stop outranks any tick due this cycle; prescaler phase is frozen
      if (state_q == S_RUNNING) begin
        state_d = S_PAUSED;
      end
    end else if (start && (state_q != S_RUNNING)) begin
      if (w_count_nz) begin
        state_d = S_RUNNING;
      end
    end else if (state_q == S_RUNNING) begin
      if (presc_q == c_presc_last) begin
        presc_d = '0;
        if (w_final_tick) begin
          expired_d = 1'b1;
          if (w_reload_nz) begin
            min_d = w_reload_min;
            sec_d = w_reload_sec;
          end else begin
            min_d   = 8'd0;
            sec_d   = 6'd0;
            state_d = S_EXPIRED;
          end
        end else if (sec_q != 6'd0) begin
          sec_d = sec_q - 6'd1;
        end else begin
          min_d = min_q - 8'd1;
          sec_d = c_sec_max;
        end
      end else begin
        presc_d = presc_q + c_presc_one;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      min_q     <= 8'd0;
      sec_q     <= 6'd0;
      presc_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      presc_q   <= presc_d;
      expired_q <= expired_d;
    end
  end

  assign minutes = min_q;
  assign seconds = sec_q;
  assign status  = state_q;
  assign expired = expired_q;

endmodule
`default_nettype wire
